// File: rtl/template_matcher.sv
// Template matcher: correlates one captured block of signed samples against
// NUM_TEMPLATES stored reference templates. It reports the index of the
// template with the highest dot-product score, that score, and whether the
// score falls below THRESH.
module template_matcher #(
  parameter int NUM_TEMPLATES = 4,
  parameter int SAMPLE_W      = 8,
  parameter int LEN           = 2000,
  parameter int THRESH        = 0,
  localparam int IDX_W = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1,
  localparam int CNT_W = $clog2(LEN + 1),
  localparam int ACC_W = 2 * SAMPLE_W + $clog2(LEN) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic                       tmpl_wr_en,
  input  logic [IDX_W-1:0]           tmpl_wr_sel,
  input  logic [CNT_W-1:0]           tmpl_wr_addr,
  input  logic signed [SAMPLE_W-1:0] tmpl_wr_data,
  output logic                       busy,
  output logic [IDX_W-1:0]           result,
  output logic                       no_match,
  output logic signed [ACC_W-1:0]    best_score,
  output logic                       result_valid,
  input  logic                       result_ready
);

  // Address width that exactly covers LEN template entries.
  localparam int AW     = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PROD_W = 2 * SAMPLE_W;
  // The scan counter needs one extra bit so it can count up to NUM_TEMPLATES.
  localparam int SCAN_W = IDX_W + 1;

  localparam logic [CNT_W-1:0]        LAST_CNT   = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0]        LEN_CNT    = CNT_W'(LEN);
  localparam logic [SCAN_W-1:0]       NUM_SCAN   = SCAN_W'(NUM_TEMPLATES);
  localparam logic signed [ACC_W-1:0] THRESH_ACC = ACC_W'(THRESH);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FLUSH,
    COMPARE,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Template storage. It has no reset; it holds whatever was last written.
  logic signed [SAMPLE_W-1:0] r_tmpl [NUM_TEMPLATES][LEN];

  logic [CNT_W-1:0]         r_count;
  logic signed [PROD_W-1:0] r_prod [NUM_TEMPLATES];
  logic                     r_prod_valid;
  logic signed [ACC_W-1:0]  r_acc  [NUM_TEMPLATES];

  logic [SCAN_W-1:0]       r_scan_idx;
  logic signed [ACC_W-1:0] r_cand;
  logic [IDX_W-1:0]        r_cand_idx;
  logic                    r_cand_valid;
  logic signed [ACC_W-1:0] r_best;
  logic [IDX_W-1:0]        r_best_idx;
  logic                    r_no_match;

  logic                     w_accept;
  logic                     w_last;
  logic                     w_wr_ok;
  logic [AW-1:0]            w_rd_addr;
  logic [AW-1:0]            w_wr_addr;
  logic                     w_scan_last;
  logic [IDX_W-1:0]         w_scan_sel;
  logic signed [PROD_W-1:0] w_prod [NUM_TEMPLATES];
  logic                     w_take;
  logic signed [ACC_W-1:0]  w_best_nxt;
  logic [IDX_W-1:0]         w_best_idx_nxt;

  assign w_accept    = (r_state == ACCUM) && sample_valid;
  assign w_last      = w_accept && (r_count == LAST_CNT);
  assign w_wr_ok     = tmpl_wr_en && (r_state == IDLE) &&
                       (tmpl_wr_addr < LEN_CNT) &&
                       ({1'b0, tmpl_wr_sel} < NUM_SCAN);
  assign w_rd_addr   = r_count[AW-1:0];
  assign w_wr_addr   = tmpl_wr_addr[AW-1:0];
  assign w_scan_last = (r_scan_idx == NUM_SCAN);
  assign w_scan_sel  = r_scan_idx[IDX_W-1:0];

  assign result     = r_best_idx;
  assign best_score = r_best;
  assign no_match   = r_no_match;

  // State register; reset returns to IDLE, which discards any capture in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the status outputs decoded from the current state.
  always_comb begin
    w_next       = r_state;
    sample_ready = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = ACCUM;
        end
      end
      ACCUM: begin
        sample_ready = 1'b1;
        if (w_last) begin
          w_next = FLUSH;
        end
      end
      FLUSH: begin
        w_next = COMPARE;
      end
      COMPARE: begin
        if (w_scan_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Full-precision products of the incoming sample with every template at the current index.
  always_comb begin
    for (int j = 0; j < NUM_TEMPLATES; j++) begin
      w_prod[j] = PROD_W'(sample_in) * PROD_W'(r_tmpl[j][w_rd_addr]);
    end
  end

  // Running argmax. Only a strictly greater score replaces the best, so ties keep the lower index.
  always_comb begin
    w_take         = r_cand_valid && ((r_cand_idx == '0) || (r_cand > r_best));
    w_best_nxt     = r_best;
    w_best_idx_nxt = r_best_idx;
    if (w_take) begin
      w_best_nxt     = r_cand;
      w_best_idx_nxt = r_cand_idx;
    end
  end

  // Template writes are accepted only while idle and only for in-range select and address.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_tmpl[tmpl_wr_sel][w_wr_addr] <= tmpl_wr_data;
    end
  end

  // Product pipeline stage, sample counter and per-template accumulators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count      <= '0;
      r_prod_valid <= 1'b0;
      for (int j = 0; j < NUM_TEMPLATES; j++) begin
        r_prod[j] <= '0;
        r_acc[j]  <= '0;
      end
    end else begin
      r_prod_valid <= w_accept;
      if (w_accept) begin
        r_count <= r_count + CNT_W'(1);
        for (int j = 0; j < NUM_TEMPLATES; j++) begin
          r_prod[j] <= w_prod[j];
        end
      end
      if ((r_state == IDLE) && start) begin
        r_count <= '0;
        for (int j = 0; j < NUM_TEMPLATES; j++) begin
          r_acc[j] <= '0;
        end
      end else if (r_prod_valid) begin
        for (int j = 0; j < NUM_TEMPLATES; j++) begin
          r_acc[j] <= r_acc[j] + ACC_W'(r_prod[j]);
        end
      end
    end
  end

  // Compare scan: the selected accumulator is registered into a candidate first, and the
  // candidate is compared one cycle later. This keeps the wide accumulator mux off the
  // comparator path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_idx   <= '0;
      r_cand       <= '0;
      r_cand_idx   <= '0;
      r_cand_valid <= 1'b0;
      r_best       <= '0;
      r_best_idx   <= '0;
      r_no_match   <= 1'b0;
    end else begin
      case (r_state)
        FLUSH: begin
          r_scan_idx   <= '0;
          r_cand_valid <= 1'b0;
        end
        COMPARE: begin
          r_best     <= w_best_nxt;
          r_best_idx <= w_best_idx_nxt;
          if (w_scan_last) begin
            r_cand_valid <= 1'b0;
            r_no_match   <= (w_best_nxt < THRESH_ACC);
          end else begin
            r_cand       <= r_acc[w_scan_sel];
            r_cand_idx   <= w_scan_sel;
            r_cand_valid <= 1'b1;
            r_scan_idx   <= r_scan_idx + SCAN_W'(1);
          end
        end
        default: begin
          r_cand_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/template_matcher.md
TEMPLATE_MATCHER -- requirements
Module: template_matcher

Parameters
REQ-001 The block SHALL have parameter NUM_TEMPLATES, default 4, giving the number of stored reference templates (legal range 2..16).
REQ-002 The block SHALL have parameter SAMPLE_W, default 8, giving the signed two's-complement width of each sample.
REQ-003 The block SHALL have parameter LEN, default 2000, giving the number of samples per capture and per template.
REQ-004 The block SHALL have parameter THRESH, default 0, giving the signed minimum score for a valid match.
REQ-005 The block SHALL derive IDX_W = max(1, clog2(NUM_TEMPLATES)), CNT_W = clog2(LEN+1) and ACC_W = 2*SAMPLE_W + clog2(LEN) + 1.

Interface
REQ-006 clk  input  1  rising-edge system clock; the block SHALL use this single clock.
REQ-007 reset_n  input  1  reset; asynchronous, active-low.
REQ-008 start  input  1  one-cycle pulse that begins a capture; SHALL be ignored outside IDLE.
REQ-009 sample_in  input  SAMPLE_W  signed audio sample.
REQ-010 sample_valid  input  1  sample_in is offered.
REQ-011 sample_ready  output  1  the block accepts a sample this cycle.
REQ-012 tmpl_wr_en  input  1  template write strobe.
REQ-013 tmpl_wr_sel  input  IDX_W  template select for the write.
REQ-014 tmpl_wr_addr  input  CNT_W  sample index for the write.
REQ-015 tmpl_wr_data  input  SAMPLE_W  template sample for the write.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 result  output  IDX_W  index of the best-matching template.
REQ-018 no_match  output  1  best score < THRESH.
REQ-019 best_score  output  ACC_W  signed score of the winner.
REQ-020 result_valid  output  1  result, no_match and best_score are valid.
REQ-021 result_ready  input  1  consumer acknowledges the result.

Function
REQ-022 The FSM SHALL have exactly the states IDLE, ACCUM, FLUSH, COMPARE and DONE.
REQ-023 IDLE->ACCUM SHALL occur on start; entry SHALL clear all NUM_TEMPLATES accumulators and the sample counter.
REQ-024 sample_ready SHALL be 1 only in ACCUM; a sample is accepted on a cycle where sample_valid && sample_ready.
REQ-025 For accepted sample k (0-based), every accumulator j SHALL add sample_in * template[j][k] as a full-precision signed product; ACC_W SHALL guarantee no overflow.
REQ-026 The product SHALL be registered one stage before accumulation; the counter SHALL advance only on acceptance, and gaps in sample_valid SHALL not corrupt the sum.
REQ-027 After acceptance LEN-1, the FSM SHALL go to FLUSH for one cycle to drain the product stage, then to COMPARE.
REQ-028 COMPARE SHALL scan templates 0..NUM_TEMPLATES-1 at one per cycle, keeping the running maximum; on equal scores the lower index SHALL win.
REQ-029 After the final scan cycle, the FSM SHALL enter DONE with result_valid=1.
REQ-030 result_valid SHALL rise exactly NUM_TEMPLATES+2 cycles after the edge that accepts the last sample.
REQ-031 no_match SHALL be 1 when best_score < THRESH, and result SHALL still carry the argmax index.
REQ-032 In DONE, outputs SHALL hold stable until result_valid && result_ready, after which the FSM SHALL return to IDLE on the next edge and clear result_valid.
REQ-033 If result_ready is already high on DONE entry, the handshake SHALL complete in that one cycle.
REQ-034 Template writes SHALL take effect only in IDLE; writes in any other state, or with tmpl_wr_addr >= LEN or tmpl_wr_sel >= NUM_TEMPLATES, SHALL be dropped.
REQ-035 If start and tmpl_wr_en occur together in IDLE, the write SHALL complete and the capture SHALL start.
REQ-036 A start pulse received while busy SHALL not be queued.

Reset
REQ-037 Asserting reset_n low in any state SHALL immediately force IDLE, sample_ready=0, busy=0, result_valid=0, result=0, no_match=0, best_score=0, and clear the counter and accumulators.
REQ-038 Reset SHALL NOT clear template storage; contents after power-up are undefined until written.
REQ-039 Reset asserted mid-capture SHALL discard the capture, and no result_valid SHALL follow.

Verification (NUM_TEMPLATES=4, SAMPLE_W=8, LEN=8, THRESH=0)
REQ-040 Templates j = all (j+1); capture 8 samples of 1 -> result=3, best_score=32, no_match=0, result_valid rises 6 cycles after the last accept.
REQ-041 Templates 1 and 2 identical (+5); all others -5; capture 8 samples of +2 -> result=1 (tie, lower index), best_score=80.
REQ-042 All templates +1; capture 8 samples of -128 -> best_score=-1024, no_match=1, result=0.
REQ-043 sample_valid toggling every other cycle, plus start pulses during ACCUM -> same score as gap-free capture; extra starts are ignored.
REQ-044 result_ready held low 10 cycles in DONE -> outputs stable; return to IDLE one edge after the ready pulse; tmpl_wr_en asserted during ACCUM leaves the templates unchanged.
REQ-045 reset_n low after sample 4 -> all outputs are at reset values at once; a new capture then gives the correct score with no residue.
